i2c_reg_arbiter: RTL and testbench

- Controller that sits behind i2c_peripheral's register interface.
- Shares a single downstream 8-bit register bus between two requesters: the I2C peripheral and a local host port.
- Sequences each access as request, bus transfer, then completion handshake, with round-robin arbitration and a bus timeout.
- Converts the peripheral's four-phase read/write handshakes into single-transaction bus cycles.

---
 rtl/i2c_reg_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_i2c_reg_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_arbiter.sv
// Shares one 8-bit downstream register bus between the I2C peripheral register
// interface and a local host port: round-robin grant, one access in flight, bus timeout.
module i2c_reg_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [7:0]  TIMEOUT_DATA   = 8'hFF
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic [7:0] i_i2c_register_address,
    input  logic       i_i2c_read_enable,
    output logic [7:0] o_i2c_register_data,
    output logic       o_i2c_read_valid,
    input  logic       i_i2c_read_ack,
    input  logic [7:0] i_i2c_register_data,
    input  logic       i_i2c_write_valid,
    output logic       o_i2c_write_ack,
    input  logic       i_host_req,
    input  logic       i_host_we,
    input  logic [7:0] i_host_addr,
    input  logic [7:0] i_host_wdata,
    output logic [7:0] o_host_rdata,
    output logic       o_host_done,
    output logic       o_bus_req,
    output logic       o_bus_we,
    output logic [7:0] o_bus_addr,
    output logic [7:0] o_bus_wdata,
    input  logic [7:0] i_bus_rdata,
    input  logic       i_bus_done,
    output logic       o_bus_timeout
);
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_BUS         = 3'd1,
        ST_I2C_RD_HOLD = 3'd2,
        ST_I2C_WR_HOLD = 3'd3,
        ST_HOST_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OWN_I2C_RD = 2'd0,
        OWN_I2C_WR = 2'd1,
        OWN_HOST   = 2'd2
    } owner_t;

    state_t           state_r, state_s;
    owner_t           owner_r, owner_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             prefer_i2c_r, prefer_i2c_s;
    logic             rd_armed_r, rd_armed_s;
    logic             bus_req_r, bus_req_s;
    logic             bus_we_r, bus_we_s;
    logic [7:0]       bus_addr_r, bus_addr_s;
    logic [7:0]       bus_wdata_r, bus_wdata_s;
    logic [7:0]       i2c_rdata_r, i2c_rdata_s;
    logic             i2c_rvalid_r, i2c_rvalid_s;
    logic             i2c_wack_r, i2c_wack_s;
    logic [7:0]       host_rdata_r, host_rdata_s;
    logic             host_done_r, host_done_s;
    logic             timeout_r, timeout_s;

    logic             i2c_req_s;
    logic             grant_i2c_s;
    logic             bus_fin_s;
    logic [7:0]       bus_data_s;

    // A read is only offered once per read_enable assertion; writes win over reads.
    assign i2c_req_s   = i_i2c_write_valid | (i_i2c_read_enable & rd_armed_r);
    assign grant_i2c_s = i2c_req_s & (~i_host_req | prefer_i2c_r);
    assign bus_fin_s   = i_bus_done | (cnt_r == CNT_LAST);
    assign bus_data_s  = i_bus_done ? i_bus_rdata : TIMEOUT_DATA;

    // Next-state, grant and output-register decode.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        cnt_s        = cnt_r;
        prefer_i2c_s = prefer_i2c_r;
        rd_armed_s   = rd_armed_r | ~i_i2c_read_enable;
        bus_req_s    = bus_req_r;
        bus_we_s     = bus_we_r;
        bus_addr_s   = bus_addr_r;
        bus_wdata_s  = bus_wdata_r;
        i2c_rdata_s  = i2c_rdata_r;
        i2c_rvalid_s = i2c_rvalid_r;
        i2c_wack_s   = i2c_wack_r;
        host_rdata_s = host_rdata_r;
        host_done_s  = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i2c_req_s || i_host_req) begin
                    state_s   = ST_BUS;
                    bus_req_s = 1'b1;
                    cnt_s     = '0;
                    // Round-robin pointer moves only when both sides actually contend.
                    if (i2c_req_s && i_host_req) begin
                        prefer_i2c_s = ~grant_i2c_s;
                    end else begin
                        prefer_i2c_s = prefer_i2c_r;
                    end
                    if (grant_i2c_s) begin
                        owner_s     = i_i2c_write_valid ? OWN_I2C_WR : OWN_I2C_RD;
                        bus_we_s    = i_i2c_write_valid;
                        bus_addr_s  = i_i2c_register_address;
                        bus_wdata_s = i_i2c_register_data;
                    end else begin
                        owner_s     = OWN_HOST;
                        bus_we_s    = i_host_we;
                        bus_addr_s  = i_host_addr;
                        bus_wdata_s = i_host_wdata;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (bus_fin_s) begin
                    bus_req_s = 1'b0;
                    cnt_s     = '0;
                    timeout_s = ~i_bus_done;
                    case (owner_r)
                        OWN_I2C_RD: begin
                            i2c_rdata_s  = bus_data_s;
                            i2c_rvalid_s = 1'b1;
                            state_s      = ST_I2C_RD_HOLD;
                        end
                        OWN_I2C_WR: begin
                            i2c_wack_s = 1'b1;
                            state_s    = ST_I2C_WR_HOLD;
                        end
                        OWN_HOST: begin
                            host_rdata_s = bus_we_r ? host_rdata_r : bus_data_s;
                            host_done_s  = 1'b1;
                            state_s      = ST_HOST_DONE;
                        end
                        default: begin
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_I2C_RD_HOLD: begin
                if (i_i2c_read_ack) begin
                    i2c_rvalid_s = 1'b0;
                    rd_armed_s   = ~i_i2c_read_enable;
                    state_s      = ST_IDLE;
                end else begin
                    i2c_rvalid_s = 1'b1;
                end
            end
            ST_I2C_WR_HOLD: begin
                if (!i_i2c_write_valid) begin
                    i2c_wack_s = 1'b0;
                    state_s    = ST_IDLE;
                end else begin
                    i2c_wack_s = 1'b1;
                end
            end
            ST_HOST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                bus_req_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any transaction in flight.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_I2C_RD;
            cnt_r        <= '0;
            prefer_i2c_r <= 1'b1;
            rd_armed_r   <= 1'b1;
            bus_req_r    <= 1'b0;
            bus_we_r     <= 1'b0;
            bus_addr_r   <= 8'h00;
            bus_wdata_r  <= 8'h00;
            i2c_rdata_r  <= 8'h00;
            i2c_rvalid_r <= 1'b0;
            i2c_wack_r   <= 1'b0;
            host_rdata_r <= 8'h00;
            host_done_r  <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            cnt_r        <= cnt_s;
            prefer_i2c_r <= prefer_i2c_s;
            rd_armed_r   <= rd_armed_s;
            bus_req_r    <= bus_req_s;
            bus_we_r     <= bus_we_s;
            bus_addr_r   <= bus_addr_s;
            bus_wdata_r  <= bus_wdata_s;
            i2c_rdata_r  <= i2c_rdata_s;
            i2c_rvalid_r <= i2c_rvalid_s;
            i2c_wack_r   <= i2c_wack_s;
            host_rdata_r <= host_rdata_s;
            host_done_r  <= host_done_s;
            timeout_r    <= timeout_s;
        end
    end

    assign o_i2c_register_data = i2c_rdata_r;
    assign o_i2c_read_valid    = i2c_rvalid_r;
    assign o_i2c_write_ack     = i2c_wack_r;
    assign o_host_rdata        = host_rdata_r;
    assign o_host_done         = host_done_r;
    assign o_bus_req           = bus_req_r;
    assign o_bus_we            = bus_we_r;
    assign o_bus_addr          = bus_addr_r;
    assign o_bus_wdata         = bus_wdata_r;
    assign o_bus_timeout       = timeout_r;
endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Randomized bench for i2c_reg_arbiter: a transaction-level model predicts the grant
// order, bus fields, bus duration, timeout and the completion handshake of every access.
module tb_i2c_reg_arbiter;
    localparam int TO = 8;

    logic       sys_clk;
    logic       rst;
    logic [7:0] i_i2c_register_address;
    logic       i_i2c_read_enable;
    logic [7:0] o_i2c_register_data;
    logic       o_i2c_read_valid;
    logic       i_i2c_read_ack;
    logic [7:0] i_i2c_register_data;
    logic       i_i2c_write_valid;
    logic       o_i2c_write_ack;
    logic       i_host_req;
    logic       i_host_we;
    logic [7:0] i_host_addr;
    logic [7:0] i_host_wdata;
    logic [7:0] o_host_rdata;
    logic       o_host_done;
    logic       o_bus_req;
    logic       o_bus_we;
    logic [7:0] o_bus_addr;
    logic [7:0] o_bus_wdata;
    logic [7:0] i_bus_rdata;
    logic       i_bus_done;
    logic       o_bus_timeout;
    logic [37:0] all_outs;

    i2c_reg_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(8'hFF)) dut (
        .i_sys_clk(sys_clk), .i_rst(rst),
        .i_i2c_register_address(i_i2c_register_address),
        .i_i2c_read_enable(i_i2c_read_enable),
        .o_i2c_register_data(o_i2c_register_data),
        .o_i2c_read_valid(o_i2c_read_valid),
        .i_i2c_read_ack(i_i2c_read_ack),
        .i_i2c_register_data(i_i2c_register_data),
        .i_i2c_write_valid(i_i2c_write_valid),
        .o_i2c_write_ack(o_i2c_write_ack),
        .i_host_req(i_host_req), .i_host_we(i_host_we),
        .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
        .o_host_rdata(o_host_rdata), .o_host_done(o_host_done),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
        .i_bus_rdata(i_bus_rdata), .i_bus_done(i_bus_done),
        .o_bus_timeout(o_bus_timeout)
    );

    assign all_outs = {o_i2c_register_data, o_i2c_read_valid, o_i2c_write_ack, o_host_rdata,
                       o_host_done, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_timeout};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: arbitration preference and read re-arm, last returned data.
    bit         m_prefer_i2c = 1'b1;
    bit         m_rd_armed   = 1'b1;
    logic [7:0] m_host_rdata = 8'h00;
    logic [7:0] m_i2c_rdata  = 8'h00;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_i2c_register_address = 8'h00; i_i2c_read_enable = 1'b0; i_i2c_read_ack = 1'b0;
        i_i2c_register_data = 8'h00; i_i2c_write_valid = 1'b0;
        i_host_req = 1'b0; i_host_we = 1'b0; i_host_addr = 8'h00; i_host_wdata = 8'h00;
        i_bus_rdata = 8'h00; i_bus_done = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_outputs_zero", all_outs, 64'd0);
        clear_inputs();
        m_prefer_i2c = 1'b1; m_rd_armed = 1'b1; m_host_rdata = 8'h00; m_i2c_rdata = 8'h00;
        #2 rst = 1'b0;
        tick();
        check_eq("post_rst_idle", o_bus_req, 64'd0);
    endtask

    // Serve the next access the model expects; d = bus cycle in which done is returned.
    task automatic serve_one(input int d, input logic [7:0] rd_data, input int keep_rd);
        bit i2c_p, g_i2c, exp_we, exp_to, kp;
        logic [7:0] exp_addr, exp_wdata, exp_data;
        int wait_n, hc, exp_hc, k;
        i2c_p  = i_i2c_write_valid || (i_i2c_read_enable && m_rd_armed);
        g_i2c  = i2c_p && (!i_host_req || m_prefer_i2c);
        if (i2c_p && i_host_req) m_prefer_i2c = !g_i2c;
        exp_we    = g_i2c ? i_i2c_write_valid : i_host_we;
        exp_addr  = g_i2c ? i_i2c_register_address : i_host_addr;
        exp_wdata = g_i2c ? i_i2c_register_data : i_host_wdata;
        wait_n = 0;
        while (!o_bus_req && wait_n < 10) begin tick(); wait_n++; end
        check_eq("grant_latency", wait_n, 1);
        check_eq("bus_we", o_bus_we, exp_we);
        check_eq("bus_addr", o_bus_addr, exp_addr);
        if (exp_we) check_eq("bus_wdata", o_bus_wdata, exp_wdata);
        hc = 0;
        while (o_bus_req && hc < 4 * TO) begin
            hc++;
            if (hc == d) begin i_bus_done = 1'b1; i_bus_rdata = rd_data; end
            tick();
            i_bus_done = 1'b0;
        end
        exp_hc   = (d < TO) ? d : TO;
        exp_to   = (d > TO);
        exp_data = exp_to ? 8'hFF : rd_data;
        check_eq("bus_req_cycles", hc, exp_hc);
        check_eq("bus_timeout", o_bus_timeout, exp_to);
        check_eq("bus_addr_stable", o_bus_addr, exp_addr);
        k = $urandom_range(0, 2);
        if (!g_i2c) begin
            check_eq("host_done", o_host_done, 1);
            if (!exp_we) m_host_rdata = exp_data;
            check_eq("host_rdata", o_host_rdata, m_host_rdata);
            i_host_req = 1'b0;
            tick();
            check_eq("host_done_pulse", o_host_done, 0);
            check_eq("timeout_pulse", o_bus_timeout, 0);
        end else if (exp_we) begin
            check_eq("write_ack", o_i2c_write_ack, 1);
            repeat (k) begin tick(); check_eq("write_ack_hold", o_i2c_write_ack, 1); end
            i_i2c_write_valid = 1'b0;
            tick();
            check_eq("write_ack_fall", o_i2c_write_ack, 0);
        end else begin
            m_i2c_rdata = exp_data;
            check_eq("read_valid", o_i2c_read_valid, 1);
            check_eq("read_data", o_i2c_register_data, m_i2c_rdata);
            repeat (k) begin tick(); check_eq("read_valid_hold", o_i2c_read_valid, 1); end
            kp = (keep_rd == 2) ? 1'($urandom_range(0, 1)) : (keep_rd != 0);
            i_i2c_read_ack = 1'b1;
            if (!kp) i_i2c_read_enable = 1'b0;
            tick();
            i_i2c_read_ack = 1'b0;
            m_rd_armed = !kp;
            check_eq("read_valid_fall", o_i2c_read_valid, 0);
            check_eq("read_data_held", o_i2c_register_data, m_i2c_rdata);
        end
    endtask

    task automatic check_no_reaccess();
        repeat (3) begin tick(); check_eq("no_rearm_access", o_bus_req, 0); end
        i_i2c_read_enable = 1'b0;
        tick();
        m_rd_armed = 1'b1;
    endtask

    task automatic contend(input logic [7:0] rdata);
        i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 8'h20;
        i_i2c_write_valid = 1'b1; i_i2c_register_address = 8'h00; i_i2c_register_data = 8'h5A;
        serve_one(2, rdata, 0);
        serve_one(2, rdata, 0);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        apply_reset();

        contend(8'h31);
        contend(8'h32);

        i_i2c_write_valid = 1'b1; i_i2c_register_address = 8'h55; i_i2c_register_data = 8'hAA;
        serve_one(3, 8'h00, 0);

        i_i2c_read_enable = 1'b1; i_i2c_register_address = 8'h10;
        serve_one(2, 8'hEF, 1);
        check_no_reaccess();
        i_i2c_read_enable = 1'b1;
        serve_one(1, 8'h42, 0);

        i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 8'h7F;
        serve_one(TO + 5, 8'h11, 0);
        i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 8'h7F;
        serve_one(TO, 8'h3C, 0);

        i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 8'h33;
        tick();
        check_eq("bus_req_before_rst", o_bus_req, 1);
        apply_reset();
        contend(8'h44);

        i_i2c_read_enable = 1'b1; i_i2c_register_address = 8'h10;
        tick();
        i_bus_done = 1'b1; i_bus_rdata = 8'h77;
        tick();
        i_bus_done = 1'b0;
        check_eq("rd_hold_before_rst", o_i2c_read_valid, 1);
        apply_reset();
        contend(8'h55);

        for (int it = 0; it < 30; it++) begin
            int wh, wi, n;
            if (i_i2c_read_enable) check_no_reaccess();
            wh = $urandom_range(0, 1);
            wi = $urandom_range(0, 3);
            if (wh == 0 && wi == 0) wi = 1;
            n = 0;
            i_i2c_register_address = 8'($urandom);
            if (wh != 0) begin
                i_host_req = 1'b1; i_host_we = 1'($urandom_range(0, 1));
                i_host_addr = 8'($urandom); i_host_wdata = 8'($urandom); n++;
            end
            if ((wi & 1) != 0) begin
                i_i2c_write_valid = 1'b1; i_i2c_register_data = 8'($urandom); n++;
            end
            if ((wi & 2) != 0) begin
                i_i2c_read_enable = 1'b1; n++;
            end
            for (int t = 0; t < n; t++) serve_one($urandom_range(1, TO + 2), 8'($urandom), 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
